// File: rtl/mips_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// mips_muldiv_unit_if
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start   : request strobe (the unit accepts it only when not busy)
//   op      : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b    : operands (a is also the MTHI/MTLO source)
//   busy    : iterative operation in flight, so the pipeline must stall
//   done    : one-cycle completion pulse; hi/lo are final in that cycle
//   hi, lo  : architectural HI/LO registers
//   divzero : divide-by-zero flag (always 0 unless the flag feature is built)
// Modports: master drives the request side, slave is the unit itself.
// ----------------------------------------------------------------------------
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, divzero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, divzero
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// ----------------------------------------------------------------------------
// mips_muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers.
// It handles MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract)
// at one bit per cycle, and MTHI/MTLO as single-cycle writes.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mips_muldiv_unit_if.slave (start/op/a/b in, busy/done/hi/lo/divzero out)
//
// Optional build macro: MULDIV_DIVZERO_FLAG_EN
//   defined   -> divzero rises with done when a DIV/DIVU finishes with b=0,
//                and it clears on the next accept.
//   undefined -> divzero is tied to 0.
//
// Timeline of an arithmetic op: accept edge -> WIDTH CALC cycles -> one FIX
// cycle (sign correction; HI/LO are written at the FIX->DONE edge) -> DONE.
// ----------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_muldiv_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier bits still to consume / dividend bits becoming quotient.
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   a_orig_reg;    // raw dividend, needed for the b=0 result
    logic               is_div_reg;
    logic               neg_res_reg;   // product/quotient sign differs from magnitude
    logic               neg_rem_reg;   // remainder follows the dividend sign
    logic               b_zero_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    // ---------------- accept decode ----------------
    logic can_accept, op_arith, op_mt, accept_arith, accept_mt;
    logic op_signed;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        can_accept   = (state_reg == S_IDLE) || (state_reg == S_DONE);
        op_arith     = ~bus.op[2];
        op_mt        = bus.op[2] & ~bus.op[1];
        accept_arith = bus.start & can_accept & op_arith;
        accept_mt    = bus.start & can_accept & op_mt;
        op_signed    = ~bus.op[0];
        a_neg        = op_signed & bus.a[WIDTH-1];
        b_neg        = op_signed & bus.b[WIDTH-1];
        // The magnitude of MIN is itself read as unsigned, which is what we want.
        abs_a        = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        abs_b        = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
    end

    // ---------------- iteration step ----------------
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        acc_hi    = acc_reg[2*WIDTH-1:WIDTH];
        acc_lo    = acc_reg[WIDTH-1:0];
        // Shift-add: add the multiplicand when the current multiplier LSB is 1,
        // then shift the whole accumulator right, carry included.
        mul_sum   = {1'b0, acc_hi} + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        // Restoring divide: bring in the next dividend bit, then keep the
        // difference only if it did not go negative.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        if (is_div_reg) begin
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_lo[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_res_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
        if (!is_div_reg) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (b_zero_reg) begin
            // Divide by zero returns a fixed pattern rather than the raw
            // iteration result, which would be sign-mangled for signed ops.
            fix_hi = a_orig_reg;
            fix_lo = {WIDTH{1'b1}};
        end else begin
            fix_hi = neg_rem_reg ? (~acc_hi + WIDTH'(1)) : acc_hi;
            fix_lo = neg_res_reg ? (~acc_lo + WIDTH'(1)) : acc_lo;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept_arith) begin
                    state_next = S_CALC;
                end else if (accept_mt) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = (state_reg == S_CALC) || (state_reg == S_FIX);
        bus.done = (state_reg == S_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            a_orig_reg  <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            b_zero_reg  <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            if (accept_arith) begin
                is_div_reg  <= bus.op[1];
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                b_zero_reg  <= (bus.b == '0);
                a_orig_reg  <= bus.a;
                cnt_reg     <= CNT_W'(WIDTH);
                if (bus.op[1]) begin
                    acc_reg  <= {{WIDTH{1'b0}}, abs_a};
                    opnd_reg <= abs_b;
                end else begin
                    acc_reg  <= {{WIDTH{1'b0}}, abs_b};
                    opnd_reg <= abs_a;
                end
            end else if (accept_mt) begin
                if (bus.op[0]) begin
                    lo_reg <= bus.a;
                end else begin
                    hi_reg <= bus.a;
                end
            end else if (state_reg == S_CALC) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end else if (state_reg == S_FIX) begin
                hi_reg <= fix_hi;
                lo_reg <= fix_lo;
            end
        end
    end

    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;

`ifdef MULDIV_DIVZERO_FLAG_EN
    logic divzero_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divzero_reg <= 1'b0;
        end else if (accept_arith || accept_mt) begin
            divzero_reg <= 1'b0;
        end else if (state_reg == S_FIX) begin
            divzero_reg <= is_div_reg & b_zero_reg;
        end
    end

    assign bus.divzero = divzero_reg;
`else
    assign bus.divzero = 1'b0;
`endif

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_mips_muldiv_unit
// Directed bench for mips_muldiv_unit (WIDTH=32). Expected HI/LO/divzero come
// from a behavioural model using 64-bit arithmetic and shadow HI/LO copies.
// They are queued when a request is driven and popped when done is seen.
// ----------------------------------------------------------------------------
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic clk;
    logic rst_n;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Behavioural reference: 64-bit products, SV division (truncates toward
    // zero; the remainder takes the dividend sign).
    task automatic push_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.hi = model_hi;
        e.lo = model_lo;
        e.dz = 1'b0;
        case (op)
            3'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    e.hi = a;
                    e.lo = '1;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    e.dz = 1'b1;
`endif
                end else if (op == 3'd2) begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
            chk({tag, "_divzero"}, 64'(bus.divzero), 64'(e.dz));
        end
    endtask

    // Issue one request (called #1 after an edge) and follow it to done.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int           cyc, bcnt;
        logic         held;
        logic [W-1:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        push_exp(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; bcnt = 0; held = 1'b1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            if (bus.busy === 1'b1 && (bus.hi !== h0 || bus.lo !== l0)) held = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), op[2] ? 64'd1 : 64'd34);
        chk({tag, "_busy_cycles"}, 64'(bcnt), op[2] ? 64'd0 : 64'd33);
        chk({tag, "_hold"}, 64'(held), 64'd1);
        pop_check(tag);
        $display("op=%s a=%h b=%h hi=%h lo=%h divzero=%0b cycles=%0d",
                 tag, a, b, bus.hi, bus.lo, bus.divzero, cyc);
    endtask

    initial begin
        int           cyc, dcnt;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_divzero", 64'(bus.divzero), 64'd0);

        // Directed cases; consecutive calls also exercise accept-from-DONE.
        run_op("MULT_m3x7",    3'd0, 32'hFFFFFFFD, 32'h00000007);
        run_op("MULTU_max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("DIV_m7d2",     3'd2, 32'hFFFFFFF9, 32'h00000002);
        run_op("DIV_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_op("DIVU_by0",     3'd3, 32'h00000007, 32'h00000000);
        run_op("DIV_by0",      3'd2, 32'hFFFFFFF9, 32'h00000000);
        run_op("MTHI",         3'd4, 32'h12345678, 32'h0);
        run_op("MTLO",         3'd5, 32'h9ABCDEF0, 32'h0);
        run_op("DIV_p7dm2",    3'd2, 32'h00000007, 32'hFFFFFFFE);
        run_op("MULT_mxm",     3'd0, 32'h80000000, 32'h80000000);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            run_op("RAND", rop, ra, rb);
        end

        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // A start while busy must be ignored and must not disturb the result.
        push_exp(3'd1, 32'h00012345, 32'h00000ABC);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h00012345; bus.b = 32'h00000ABC;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("busy_start_latency", 64'(cyc), 64'd34);
        pop_check("busy_start");
        $display("op=busy_start hi=%h lo=%h cycles=%0d", bus.hi, bus.lo, cyc);

        // Reset in the middle of CALC aborts the op and clears HI/LO.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h00000123; bus.b = 32'h00000456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_divzero", 64'(bus.divzero), 64'd0);
        model_hi = '0;
        model_lo = '0;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
        end
        chk("abort_no_resume", 64'(dcnt), 64'd0);
        $display("op=abort hi=%h lo=%h", bus.hi, bus.lo);

        // Reserved op code: no state change, no done, HI/LO untouched.
        run_op("MTHI_pre", 3'd4, 32'hCAFEF00D, 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h11111111; bus.b = 32'h2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        chk("reserved_quiet", 64'(dcnt), 64'd0);
        chk("reserved_hi", 64'(bus.hi), 64'(model_hi));
        chk("reserved_lo", 64'(bus.lo), 64'(model_lo));
        $display("op=reserved hi=%h lo=%h", bus.hi, bus.lo);

        run_op("MULTU_after", 3'd1, 32'h0000FFFF, 32'h00010001);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
